// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, 1-cycle-latency imem fetch, small return FIFO, branch redirect/flush.
// Optional performance counters (Fetch_Count, Stall_Count) are enabled by defining IF_PERF_CNT_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic [31:0] Imem_Data,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    output logic [31:0] Inst_Out,
    output logic [31:0] Pc_Out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] Fetch_Count,
    output logic [31:0] Stall_Count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]      pc_r;
    logic             inflight_r;
    logic [31:0]      inflight_pc_r;
    logic [31:0]      last_pc_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      data_mem_r [FIFO_DEPTH];
    logic [31:0]      pc_mem_r   [FIFO_DEPTH];

    logic [31:0]      target_s;
    logic             push_s;
    logic             pop_s;
    logic [CNT_W:0]   occupancy_s;

    // Fetch issue, FIFO handshake and head presentation
    always_comb begin
        target_s = Branch_Target & 32'hFFFF_FFFC;
        if (Branch_Taken) begin
            Imem_Addr = target_s;
        end else begin
            Imem_Addr = pc_r;
        end

        Inst_Valid = (count_r != {CNT_W{1'b0}});
        if (Inst_Valid && Inst_Ready && !Branch_Taken && !Reset) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end

        // A redirect kills the response returning this cycle
        push_s = inflight_r && !Branch_Taken && !Reset;

        // Credit the slot freed by a same-cycle pop so a full pipe keeps streaming
        occupancy_s = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r} - {{CNT_W{1'b0}}, pop_s};
        if (Reset) begin
            Imem_Req = 1'b0;
        end else if (Branch_Taken) begin
            Imem_Req = 1'b1;
        end else if (occupancy_s < DEPTH_C) begin
            Imem_Req = 1'b1;
        end else begin
            Imem_Req = 1'b0;
        end

        if (Inst_Valid) begin
            Inst_Out = data_mem_r[rd_ptr_r];
            Pc_Out   = pc_mem_r[rd_ptr_r];
        end else begin
            Inst_Out = NOP_INST;
            Pc_Out   = last_pc_r;
        end
    end

    // PC, in-flight tracking and FIFO pointer/count state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
            last_pc_r     <= 32'h0000_0000;
            rd_ptr_r      <= {PTR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
        end else begin
            if (Imem_Req) begin
                pc_r          <= Imem_Addr + 32'd4;
                inflight_r    <= 1'b1;
                inflight_pc_r <= Imem_Addr;
            end else begin
                inflight_r    <= 1'b0;
            end

            if (Branch_Taken) begin
                rd_ptr_r <= {PTR_W{1'b0}};
                wr_ptr_r <= {PTR_W{1'b0}};
                count_r  <= {CNT_W{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r  <= rd_ptr_r + PTR_W'(1);
                    last_pc_r <= pc_mem_r[rd_ptr_r];
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_W'(1);
                    2'b01:   count_r <= count_r - CNT_W'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // FIFO storage; contents are only observed while count_r covers them
    always_ff @(posedge Clk) begin
        if (push_s) begin
            data_mem_r[wr_ptr_r] <= Imem_Data;
            pc_mem_r[wr_ptr_r]   <= inflight_pc_r;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Issue and decode-stall counters, unaffected by redirects
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Fetch_Count <= 32'h0000_0000;
            Stall_Count <= 32'h0000_0000;
        end else begin
            if (Imem_Req) begin
                Fetch_Count <= Fetch_Count + 32'd1;
            end
            if (Inst_Valid && !Inst_Ready) begin
                Stall_Count <= Stall_Count + 32'd1;
            end
        end
    end
`endif

endmodule
